// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the microcontroller core: fetch state encoding,
// opcode field layout and the halt opcode value.
package uc_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    ISSUE,
    HALT
  } fetch_state_t;

  // Opcode occupies the top OPCODE_WIDTH bits of the instruction word
  localparam int unsigned OPCODE_WIDTH = 4;

  // Opcode that stops the fetch sequencer after it has been delivered
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF;

endpackage : uc_pkg

// File: rtl/fetch_unit_if.sv
// Program-memory read port and decoder valid/ready handshake of the fetch unit.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 16
);

  logic                   imem_en;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0]  ir_pc;
  logic                   ir_valid;
  logic                   ir_ready;

  // Fetch unit side: issues reads, offers instructions
  modport master (
    output imem_en,
    output imem_addr,
    input  imem_rdata,
    output ir,
    output ir_pc,
    output ir_valid,
    input  ir_ready
  );

  // Memory/decoder side: returns data, accepts instructions
  modport slave (
    input  imem_en,
    input  imem_addr,
    output imem_rdata,
    input  ir,
    input  ir_pc,
    input  ir_valid,
    output ir_ready
  );

endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: steers the program counter, reads program
// memory, holds the instruction register and offers it to the decoder.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter logic [uc_pkg::OPCODE_WIDTH-1:0] HALT_OPCODE = uc_pkg::HALT_OPCODE
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pc_inc,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_next,
  input  logic                  br_valid,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  resume,
  output logic                  halted,
  fetch_unit_if.master          bus
);

  import uc_pkg::*;

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  br;
  logic                  is_halt_op;

  // A redirect is ignored while reset is held so every output sits at its reset value
  assign br         = br_valid & arst_n;
  assign is_halt_op = (bus.ir[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a branch redirects to FETCH from every state
  always_comb begin
    state_next = state;
    if (br) begin
      state_next = FETCH;
    end else begin
      unique case (state)
        IDLE:    state_next = FETCH;
        FETCH:   state_next = CAPTURE;
        CAPTURE: state_next = ISSUE;
        ISSUE: begin
          if (bus.ir_ready) begin
            state_next = is_halt_op ? HALT : FETCH;
          end
        end
        HALT: begin
          if (resume) begin
            state_next = FETCH;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic; a branch overrides the increment and the memory read
  always_comb begin
    pc_inc        = 1'b0;
    pc_load       = br;
    pc_next       = br ? br_target : '0;
    bus.imem_en   = 1'b0;
    bus.imem_addr = pc_out;
    halted        = (state == HALT);
    if (state == FETCH && !br) begin
      pc_inc      = 1'b1;
      bus.imem_en = 1'b1;
    end
  end

  // Fetch address, instruction register and its valid flag
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fetch_pc     <= '0;
      bus.ir       <= '0;
      bus.ir_pc    <= '0;
      bus.ir_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!br) begin
            fetch_pc <= pc_out;
          end
        end
        CAPTURE: begin
          if (!br) begin
            bus.ir       <= bus.imem_rdata;
            bus.ir_pc    <= fetch_pc;
            bus.ir_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (br || bus.ir_ready) begin
            bus.ir_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a small program counter and synchronous memory
// model surround the DUT; per-cycle vectors plus hand-written corner cases.
module tb_fetch_unit;

  logic        clk;
  logic        arst_n;
  logic [7:0]  pc_out;
  logic        pc_inc;
  logic        pc_load;
  logic [7:0]  pc_next;
  logic        br_valid;
  logic [7:0]  br_target;
  logic        resume;
  logic        halted;

  int checks;
  int errors;

  fetch_unit_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) bus ();

  fetch_unit #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .HALT_OPCODE(4'hF)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .pc_out    (pc_out),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .br_valid  (br_valid),
    .br_target (br_target),
    .resume    (resume),
    .halted    (halted),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program contents: address + 0x1000, except a halt word at address 3
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (a == 8'h03) return 16'hF000;
    return 16'h1000 + {8'h00, a};
  endfunction

  // Program counter model
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)      pc_out <= 8'h00;
    else if (pc_load) pc_out <= pc_next;
    else if (pc_inc)  pc_out <= pc_out + 8'h01;
  end

  // Synchronous program memory model
  initial bus.imem_rdata = 16'h0000;
  always_ff @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
  end

  typedef struct {
    logic        rdy;
    logic        br;
    logic [7:0]  tgt;
    logic        res;
    logic        en;
    logic        inc;
    logic        load;
    logic [7:0]  nxt;
    logic [7:0]  pc;
    logic        valid;
    logic [15:0] ir;
    logic [7:0]  irpc;
    logic        halt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic rdy, input logic br, input logic [7:0] tgt,
                              input logic res, input logic en, input logic inc,
                              input logic load, input logic [7:0] nxt, input logic [7:0] pc,
                              input logic valid, input logic [15:0] ir,
                              input logic [7:0] irpc, input logic halt);
    vec_t v;
    v.rdy = rdy; v.br = br; v.tgt = tgt; v.res = res;
    v.en = en; v.inc = inc; v.load = load; v.nxt = nxt; v.pc = pc;
    v.valid = valid; v.ir = ir; v.irpc = irpc; v.halt = halt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic br, input logic [7:0] tgt, input logic res);
    bus.ir_ready = rdy;
    br_valid     = br;
    br_target    = tgt;
    resume       = res;
  endtask

  // Advance one cycle: drive just after the edge, settle before sampling
  task automatic step(input logic rdy, input logic br, input logic [7:0] tgt, input logic res);
    @(posedge clk);
    #1 drive(rdy, br, tgt, res);
    #3;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ir_valid"}, 32'(bus.ir_valid), 32'h0);
    chk({tag, " ir"},       32'(bus.ir),       32'h0);
    chk({tag, " ir_pc"},    32'(bus.ir_pc),    32'h0);
    chk({tag, " halted"},   32'(halted),       32'h0);
    chk({tag, " pc_inc"},   32'(pc_inc),       32'h0);
    chk({tag, " pc_load"},  32'(pc_load),      32'h0);
    chk({tag, " pc_next"},  32'(pc_next),      32'h0);
    chk({tag, " imem_en"},  32'(bus.imem_en),  32'h0);
    chk({tag, " imem_addr"}, 32'(bus.imem_addr), 32'(pc_out));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    //        rdy br tgt    res en inc ld nxt    pc     vld ir        irpc   hlt
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h00, 0,16'h0000,8'h00,0)); // 0  IDLE
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h00, 0,16'h0000,8'h00,0)); // 1  FETCH 0
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h01, 0,16'h0000,8'h00,0)); // 2  CAPTURE
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h01, 1,16'h1000,8'h00,0)); // 3  ISSUE
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h01, 0,16'h1000,8'h00,0)); // 4  FETCH 1
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h02, 0,16'h1000,8'h00,0)); // 5
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h02, 1,16'h1001,8'h01,0)); // 6
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h02, 0,16'h1001,8'h01,0)); // 7  FETCH 2
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h03, 0,16'h1001,8'h01,0)); // 8
    for (int i = 0; i < 5; i++)                                            // 9-13 stall
      tv.push_back(mk(0,0,8'h00,0, 0,0,0,8'h00, 8'h03, 1,16'h1002,8'h02,0));
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h03, 1,16'h1002,8'h02,0)); // 14 accept
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h03, 0,16'h1002,8'h02,0)); // 15 FETCH 3
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h04, 0,16'h1002,8'h02,0)); // 16
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h04, 1,16'hF000,8'h03,0)); // 17 halt word
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h04, 0,16'hF000,8'h03,1)); // 18 HALT
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h04, 0,16'hF000,8'h03,1)); // 19
    tv.push_back(mk(1,0,8'h00,1, 0,0,0,8'h00, 8'h04, 0,16'hF000,8'h03,1)); // 20 resume
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h04, 0,16'hF000,8'h03,0)); // 21 FETCH 4
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h05, 0,16'hF000,8'h03,0)); // 22
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h05, 1,16'h1004,8'h04,0)); // 23
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h05, 0,16'h1004,8'h04,0)); // 24 FETCH 5
    tv.push_back(mk(1,1,8'h40,0, 0,0,1,8'h40, 8'h06, 0,16'h1004,8'h04,0)); // 25 br in CAPTURE
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h40, 0,16'h1004,8'h04,0)); // 26 FETCH 40
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h41, 0,16'h1004,8'h04,0)); // 27
    tv.push_back(mk(0,1,8'hFF,0, 0,0,1,8'hFF, 8'h41, 1,16'h1040,8'h40,0)); // 28 br in ISSUE
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'hFF, 0,16'h1040,8'h40,0)); // 29 FETCH FF
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h00, 0,16'h1040,8'h40,0)); // 30
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h00, 1,16'h10FF,8'hFF,0)); // 31
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h00, 0,16'h10FF,8'hFF,0)); // 32 FETCH 00
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h01, 0,16'h10FF,8'hFF,0)); // 33
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h01, 1,16'h1000,8'h00,0)); // 34
    tv.push_back(mk(1,0,8'h00,0, 1,1,0,8'h00, 8'h01, 0,16'h1000,8'h00,0)); // 35 FETCH 01
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h02, 0,16'h1000,8'h00,0)); // 36
    tv.push_back(mk(1,0,8'h00,0, 0,0,0,8'h00, 8'h02, 1,16'h1001,8'h01,0)); // 37

    // Reset state while arst_n is held low
    repeat (2) @(posedge clk);
    #4 chk_reset_outputs("reset");

    // Release reset so that the following edge is edge 0
    @(posedge clk);
    #1 arst_n = 1'b1;
    foreach (tv[i]) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      drive(tv[i].rdy, tv[i].br, tv[i].tgt, tv[i].res);
      #3;
      chk($sformatf("c%0d imem_en", i),   32'(bus.imem_en),   32'(tv[i].en));
      chk($sformatf("c%0d pc_inc", i),    32'(pc_inc),        32'(tv[i].inc));
      chk($sformatf("c%0d pc_load", i),   32'(pc_load),       32'(tv[i].load));
      chk($sformatf("c%0d pc_next", i),   32'(pc_next),       32'(tv[i].nxt));
      chk($sformatf("c%0d pc_out", i),    32'(pc_out),        32'(tv[i].pc));
      chk($sformatf("c%0d imem_addr", i), 32'(bus.imem_addr), 32'(tv[i].pc));
      chk($sformatf("c%0d ir_valid", i),  32'(bus.ir_valid),  32'(tv[i].valid));
      chk($sformatf("c%0d ir", i),        32'(bus.ir),        32'(tv[i].ir));
      chk($sformatf("c%0d ir_pc", i),     32'(bus.ir_pc),     32'(tv[i].irpc));
      chk($sformatf("c%0d halted", i),    32'(halted),        32'(tv[i].halt));
    end

    // Branch during FETCH of address 2 back to the halt word at address 3
    step(1'b1, 1'b1, 8'h03, 1'b0);
    chk("br_fetch pc_load", 32'(pc_load), 32'h1);
    chk("br_fetch pc_inc", 32'(pc_inc), 32'h0);
    chk("br_fetch imem_en", 32'(bus.imem_en), 32'h0);
    chk("br_fetch pc_next", 32'(pc_next), 32'h03);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("br_fetch target pc", 32'(pc_out), 32'h03);
    chk("br_fetch target read", 32'(bus.imem_en), 32'h1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("halt2 ir", 32'(bus.ir), 32'hF000);
    chk("halt2 ir_pc", 32'(bus.ir_pc), 32'h03);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("halt2 halted", 32'(halted), 32'h1);
    chk("halt2 no read", 32'(bus.imem_en), 32'h0);

    // Branch and resume together in HALT: the branch wins
    step(1'b1, 1'b1, 8'h20, 1'b1);
    chk("halt_br pc_load", 32'(pc_load), 32'h1);
    chk("halt_br pc_next", 32'(pc_next), 32'h20);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("halt_br pc_out", 32'(pc_out), 32'h20);
    chk("halt_br halted", 32'(halted), 32'h0);
    chk("halt_br imem_en", 32'(bus.imem_en), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("pre_rst ir_valid", 32'(bus.ir_valid), 32'h1);
    chk("pre_rst ir", 32'(bus.ir), 32'h1020);

    // Asynchronous reset in the middle of ISSUE
    #2 arst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(posedge clk);
    #1 arst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    #3;
    chk("restart idle imem_en", 32'(bus.imem_en), 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("restart imem_en", 32'(bus.imem_en), 32'h1);
    chk("restart imem_addr", 32'(bus.imem_addr), 32'h00);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("restart ir_valid", 32'(bus.ir_valid), 32'h1);
    chk("restart ir", 32'(bus.ir), 32'h1000);
    chk("restart ir_pc", 32'(bus.ir_pc), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
